// File: rtl/perf_snapshot_dump_if.sv
// Stream port of the snapshot dumper: one 32-bit word per valid/ready beat,
// with out_last marking the checksum beat that closes a frame.
interface perf_snapshot_dump_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/perf_snapshot_dump.sv
// Performance counter snapshot and dump engine.
// All live counters are copied into a shadow bank in one cycle. The copy is
// triggered by an explicit request or by perf_enable falling. The shadow bank
// serves random reads and is streamed as a frame: header, counters, checksum.
// The shadow bank is frozen while a frame is in flight. Any snapshot that
// arrives during a frame is held as pending and applied once the dumper is
// idle again, so one frame always describes exactly one snapshot.
module perf_snapshot_dump #(
    parameter int NUM_CTR = 16,
    parameter int W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CTR*W-1:0] ctr_flat,
    input  logic                 perf_enable,
    input  logic                 snap_req,
    output logic [7:0]           snap_seq,
    input  logic [7:0]           rd_idx,
    output logic [W-1:0]         rd_data,
    input  logic                 dump_start,
    output logic                 dump_busy,
    perf_snapshot_dump_if.master out_if
);

    localparam logic [15:0] HDR_TAG  = 16'h5046;
    localparam logic [7:0]  CTR_CNT  = 8'(NUM_CTR);
    localparam logic [7:0]  LAST_IDX = 8'(NUM_CTR - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

    // The frame header carries a tag, the snapshot sequence number and the counter count.
    function automatic logic [31:0] make_header(input logic [7:0] seq);
        return {HDR_TAG, seq, CTR_CNT};
    endfunction

    // Running checksum: plain 32-bit sum that wraps modulo 2^32.
    function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [31:0] word);
        return acc + word;
    endfunction

    state_t       state_r;
    state_t       state_nxt_s;
    logic [7:0]   idx_r;
    logic [7:0]   idx_nxt_s;
    logic [31:0]  sum_r;
    logic [31:0]  sum_nxt_s;
    logic [W-1:0] shadow_r [NUM_CTR];
    logic [7:0]   seq_r;
    logic [7:0]   seq_nxt_s;
    logic         en_d_r;
    logic         pending_r;
    logic         trig_s;
    logic         idle_s;
    logic         apply_s;
    logic         handshake_s;
    logic         out_valid_r;
    logic         out_last_r;
    logic [31:0]  out_data_r;
    logic         out_valid_nxt_s;
    logic         out_last_nxt_s;
    logic [31:0]  out_data_nxt_s;
    logic [W-1:0] word_nxt_s;

    // Decode the snapshot trigger and decide whether the snapshot is applied this edge.
    always_comb begin
        trig_s      = snap_req | (en_d_r & ~perf_enable);
        idle_s      = (state_r == ST_IDLE);
        apply_s     = idle_s & (trig_s | pending_r);
        handshake_s = out_valid_r & out_if.out_ready;
        if (apply_s) begin
            seq_nxt_s = seq_r + 8'd1;
        end else begin
            seq_nxt_s = seq_r;
        end
    end

    // Register the enable edge detector, the sequence number and the pending snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_d_r    <= 1'b0;
            seq_r     <= 8'd0;
            pending_r <= 1'b0;
        end else begin
            en_d_r <= perf_enable;
            seq_r  <= seq_nxt_s;
            if (apply_s) begin
                pending_r <= 1'b0;
            end else if (trig_s) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    // Copy every live counter into the shadow bank when a snapshot is applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CTR; i++) begin
                shadow_r[i] <= '0;
            end
        end else if (apply_s) begin
            for (int i = 0; i < NUM_CTR; i++) begin
                shadow_r[i] <= ctr_flat[i*W +: W];
            end
        end else begin
            for (int i = 0; i < NUM_CTR; i++) begin
                shadow_r[i] <= shadow_r[i];
            end
        end
    end

    // Random read port into the shadow bank; indexes beyond the bank read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CTR; i++) begin
            if (rd_idx == 8'(i)) begin
                rd_data = shadow_r[i];
            end else begin
                rd_data = rd_data;
            end
        end
    end

    // Dump sequencer: next state, word index and running checksum.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        sum_nxt_s   = sum_r;
        case (state_r)
            ST_IDLE: begin
                if (dump_start) begin
                    state_nxt_s = ST_HDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (handshake_s) begin
                    state_nxt_s = ST_DATA;
                    idx_nxt_s   = 8'd0;
                    sum_nxt_s   = 32'd0;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_DATA: begin
                if (handshake_s) begin
                    // out_data_r holds shadow[idx_r] for the whole DATA beat.
                    sum_nxt_s = csum_add(sum_r, out_data_r);
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = ST_CSUM;
                    end else begin
                        idx_nxt_s = idx_r + 8'd1;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (handshake_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CSUM;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = 8'd0;
                sum_nxt_s   = 32'd0;
            end
        endcase
    end

    // Select the shadow word that the next DATA beat will present.
    always_comb begin
        word_nxt_s = '0;
        for (int i = 0; i < NUM_CTR; i++) begin
            if (idx_nxt_s == 8'(i)) begin
                word_nxt_s = shadow_r[i];
            end else begin
                word_nxt_s = word_nxt_s;
            end
        end
    end

    // Compute the stream outputs for the next state so that they can be registered.
    always_comb begin
        out_valid_nxt_s = (state_nxt_s != ST_IDLE);
        out_last_nxt_s  = (state_nxt_s == ST_CSUM);
        case (state_nxt_s)
            ST_HDR:  out_data_nxt_s = make_header(seq_nxt_s);
            ST_DATA: out_data_nxt_s = word_nxt_s;
            ST_CSUM: out_data_nxt_s = sum_nxt_s;
            default: out_data_nxt_s = 32'd0;
        endcase
    end

    // Register the sequencer state and the stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= 8'd0;
            sum_r       <= 32'd0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= 32'd0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            sum_r       <= sum_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_last_r  <= out_last_nxt_s;
            out_data_r  <= out_data_nxt_s;
        end
    end

    assign snap_seq         = seq_r;
    assign dump_busy        = out_valid_r;
    assign out_if.out_valid = out_valid_r;
    assign out_if.out_last  = out_last_r;
    assign out_if.out_data  = out_data_r;

endmodule

// File: tb/tb_perf_snapshot_dump.sv
// Testbench for perf_snapshot_dump. A frame-level model predicts the sequence
// number, the shadow contents and the queue of expected beats. A negedge
// process compares the DUT against the model every cycle. Directed scenarios
// add hand-computed literal expectations.
module tb_perf_snapshot_dump;
    localparam int NUM_CTR = 16;
    localparam int W       = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 perf_enable;
    logic                 snap_req;
    logic                 dump_start;
    logic [7:0]           rd_idx;
    logic [7:0]           snap_seq;
    logic [W-1:0]         rd_data;
    logic                 dump_busy;
    logic [W-1:0]         ctr [NUM_CTR];
    logic [NUM_CTR*W-1:0] ctr_flat;

    perf_snapshot_dump_if bus ();

    perf_snapshot_dump #(.NUM_CTR(NUM_CTR), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ctr_flat    (ctr_flat),
        .perf_enable (perf_enable),
        .snap_req    (snap_req),
        .snap_seq    (snap_seq),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .dump_start  (dump_start),
        .dump_busy   (dump_busy),
        .out_if      (bus.master)
    );

    always #5 clk = ~clk;

    always_comb begin
        ctr_flat = '0;
        for (int i = 0; i < NUM_CTR; i++) ctr_flat[i*W +: W] = ctr[i];
    end

    int   checks  = 0;
    int   errors  = 0;
    bit   started = 1'b0;
    logic [31:0] rx [$];

    // Model state: a 256-entry shadow, so indexes past NUM_CTR read as zero.
    logic [31:0] m_shadow [256];
    logic [7:0]  m_seq;
    bit          m_pend;
    bit          m_en_d;
    logic [31:0] m_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (dump_busy && n < budget) begin
            tick();
            n++;
        end
        chk(name, {31'd0, dump_busy}, 32'd0);
    endtask

    // Frame-level model: snapshots, the pending flag, and the expected beat queue.
    always @(posedge clk) begin
        bit idle;
        bit trig;
        logic [31:0] s;
        if (rst) begin
            m_q.delete();
            m_seq  = 8'd0;
            m_pend = 1'b0;
            m_en_d = 1'b0;
            for (int i = 0; i < 256; i++) m_shadow[i] = 32'd0;
        end else begin
            idle = (m_q.size() == 0);
            trig = snap_req || (m_en_d && !perf_enable);
            if (idle && (trig || m_pend)) begin
                for (int i = 0; i < NUM_CTR; i++) m_shadow[i] = ctr[i];
                m_seq  = m_seq + 8'd1;
                m_pend = 1'b0;
            end else if (trig) begin
                m_pend = 1'b1;
            end
            m_en_d = perf_enable;
            if (!idle && bus.out_ready) void'(m_q.pop_front());
            if (idle && dump_start) begin
                m_q.push_back({16'h5046, m_seq, 8'(NUM_CTR)});
                s = 32'd0;
                for (int i = 0; i < NUM_CTR; i++) begin
                    m_q.push_back(m_shadow[i]);
                    s = s + m_shadow[i];
                end
                m_q.push_back(s);
            end
        end
    end

    // Compare the DUT against the model every cycle, and log transferred beats.
    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_q.size() != 0});
            chk("dump_busy", {31'd0, dump_busy}, {31'd0, m_q.size() != 0});
            chk("snap_seq", {24'd0, snap_seq}, {24'd0, m_seq});
            chk("rd_data", rd_data, m_shadow[rd_idx]);
            if (m_q.size() != 0) begin
                chk("out_data", bus.out_data, m_q[0]);
                chk("out_last", {31'd0, bus.out_last}, {31'd0, m_q.size() == 1});
            end
            if (!rst && bus.out_valid && bus.out_ready) rx.push_back(bus.out_data);
        end
    end

    initial begin
        bit injected;
        bit [3:0] pat;
        int n;
        rst = 1'b1; perf_enable = 1'b0; snap_req = 1'b0; dump_start = 1'b0;
        rd_idx = 8'd0; bus.out_ready = 1'b0;
        for (int i = 0; i < NUM_CTR; i++) ctr[i] = 32'd0;
        tick();
        tick();
        started = 1'b1;
        rst = 1'b0;
        tick();
        // Reset state.
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, bus.out_last}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_busy", {31'd0, dump_busy}, 32'd0);
        chk("rst_seq", {24'd0, snap_seq}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);

        // Basic dump: counter i = 0x100+i.
        for (int i = 0; i < NUM_CTR; i++) ctr[i] = 32'h100 + 32'(i);
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        rx.delete();
        dump_start = 1'b1; bus.out_ready = 1'b1; tick(); dump_start = 1'b0;
        wait_idle(100, "basic_timeout");
        chk("basic_beats", rx.size(), 32'd18);
        if (rx.size() == 18) begin
            chk("basic_hdr", rx[0], 32'h5046_0110);
            chk("basic_d0", rx[1], 32'h0000_0100);
            chk("basic_d15", rx[16], 32'h0000_010F);
            // 16*0x100 + (0+1+...+15) = 0x1000 + 0x78
            chk("basic_csum", rx[17], 32'h0000_1078);
        end

        // perf_enable falling edge triggers a snapshot exactly once.
        ctr[0] = 32'd1234;
        perf_enable = 1'b1; tick(); tick();
        perf_enable = 1'b0; rd_idx = 8'd0; tick();
        chk("en_fall_rd", rd_data, 32'd1234);
        chk("en_fall_seq", {24'd0, snap_seq}, 32'd2);
        repeat (5) tick();
        chk("en_steady_seq", {24'd0, snap_seq}, 32'd2);

        // Backpressure 1,0,0,1 with wrapping counter values.
        for (int i = 0; i < NUM_CTR; i++) ctr[i] = 32'hF000_0000 + 32'(i * 7);
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        rx.delete();
        pat = 4'b1001;
        dump_start = 1'b1; bus.out_ready = 1'b1; tick(); dump_start = 1'b0;
        n = 0;
        while (dump_busy && n < 300) begin
            bus.out_ready = pat[3 - (n % 4)];
            rd_idx = 8'(n % 20);
            tick();
            n++;
        end
        chk("bp_timeout", {31'd0, dump_busy}, 32'd0);
        chk("bp_beats", rx.size(), 32'd18);
        if (rx.size() == 18) begin
            chk("bp_hdr", rx[0], 32'h5046_0310);
            // 16*0xF0000000 wraps to 0, plus 7*(0+...+15) = 840
            chk("bp_csum", rx[17], 32'h0000_0348);
        end

        // Snapshot request during a dump is deferred until idle.
        bus.out_ready = 1'b1;
        for (int i = 0; i < NUM_CTR; i++) ctr[i] = 32'h200 + 32'(i);
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        rx.delete();
        dump_start = 1'b1; tick(); dump_start = 1'b0;
        injected = 1'b0; n = 0;
        while (dump_busy && n < 100) begin
            if (rx.size() == 5 && !injected) begin
                for (int i = 0; i < NUM_CTR; i++) ctr[i] = 32'h300 + 32'(i);
                snap_req = 1'b1;
                injected = 1'b1;
            end else begin
                snap_req = 1'b0;
            end
            tick();
            n++;
        end
        snap_req = 1'b0;
        chk("defer_timeout", {31'd0, dump_busy}, 32'd0);
        chk("defer_beats", rx.size(), 32'd18);
        if (rx.size() == 18) begin
            chk("defer_hdr", rx[0], 32'h5046_0410);
            chk("defer_d5", rx[6], 32'h0000_0205);
        end
        rd_idx = 8'd3;
        tick();
        chk("defer_seq", {24'd0, snap_seq}, 32'd5);
        chk("defer_rd", rd_data, 32'h0000_0303);

        // Reset in the middle of a frame.
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        rx.delete();
        dump_start = 1'b1; tick(); dump_start = 1'b0;
        n = 0;
        while (rx.size() < 7 && n < 100) begin
            tick();
            n++;
        end
        chk("rst_mid_reach", rx.size(), 32'd7);
        rst = 1'b1; rd_idx = 8'd0; tick(); rst = 1'b0;
        chk("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_mid_seq", {24'd0, snap_seq}, 32'd0);
        chk("rst_mid_rd", rd_data, 32'd0);
        tick();

        // 256 snapshots wrap the sequence number back to 0.
        snap_req = 1'b1;
        repeat (256) tick();
        snap_req = 1'b0;
        tick();
        chk("wrap_seq", {24'd0, snap_seq}, 32'd0);

        // dump_start pulses while busy are ignored: exactly one frame.
        rx.delete();
        dump_start = 1'b1; tick();
        n = 0;
        while (dump_busy && n < 100) begin
            dump_start = (n < 10) && (n % 2 == 0);
            tick();
            n++;
        end
        dump_start = 1'b0;
        chk("ign_timeout", {31'd0, dump_busy}, 32'd0);
        repeat (4) tick();
        chk("ign_beats", rx.size(), 32'd18);
        chk("ign_busy", {31'd0, dump_busy}, 32'd0);
        if (rx.size() == 18) chk("ign_hdr", rx[0], 32'h5046_0010);
        rd_idx = 8'd20;
        tick();
        chk("rd_oob", rd_data, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
